tiny_fetch_sequencer: RTL and testbench
=======================================

Name: tiny_fetch_sequencer

Overview:
- Instruction-fetch controller for the TinyMcu program ROM.
- Owns the program counter (PC) and drives the ROM read address.
- Accounts for the ROM's 1-cycle synchronous read latency.
- Hands each fetched instruction to the decoder with a valid/ready handshake, and handles jumps, run/stop control and out-of-range faults.

Parameters:
- ADDR_W, 5, ROM address width.
- DATA_W, 8, instruction width.
- PROG_LEN, 16, number of valid program words; PC wraps at PROG_LEN-1.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  system clock, all logic on posedge.
- nReset  in  1  synchronous active-low reset.
- run  in  1  level; 1 = fetch, 0 = stop after current handshake.
- romAddr  out  ADDR_W  ROM read address; always equals PC register.
- romData  in  DATA_W  ROM read data, valid 1 cycle after address is sampled.
- instr  out  DATA_W  fetched instruction.
- instrPc  out  ADDR_W  address instr was fetched from.
- instrValid  out  1  instr/instrPc valid.
- instrReady  in  1  decoder accepts instr when instrValid&&instrReady.
- jumpEn  in  1  one-cycle redirect request.
- jumpAddr  in  ADDR_W  redirect target.
- busy  out  1  state != IDLE && state != FAULT.
- fault  out  1  sticky; set on out-of-range jump.

Behaviour:
- One clock; reset is synchronous and active-low on nReset; clock is clock.
- Reset values:
  - pc=RESET_PC, state=IDLE.
  - instr=0, instrPc=0, instrValid=0, fault=0, busy=0.
- States: IDLE, ISSUE, CAPTURE, HOLD, FAULT.
- IDLE: instrValid=0. run=1 -> ISSUE.
- ISSUE: romAddr=pc is sampled by the ROM this edge -> CAPTURE.
- CAPTURE (romData now corresponds to pc):
  - instr<=romData, instrPc<=pc, instrValid<=1.
  - pc<=next(pc).
  - -> HOLD.
- HOLD:
  - instr, instrPc and instrValid stay stable until a handshake.
  - On instrValid&&instrReady: instrValid<=0; run ? ISSUE : IDLE.
- Throughput and latency:
  - Minimum 3 cycles per instruction with instrReady held high.
  - First instrValid rises 2 cycles after run is seen high in IDLE.
- next(pc) = (pc==PROG_LEN-1) ? 0 : pc+1. No bits above ADDR_W are ever produced.
- jumpEn has priority over all other transitions in IDLE/ISSUE/CAPTURE/HOLD:
  - jumpAddr<PROG_LEN: pc<=jumpAddr. An in-flight or held instruction is discarded (instrValid<=0, no handshake counted).
    - IDLE stays IDLE; other states -> ISSUE.
    - A handshake in the same HOLD cycle as jumpEn still counts as accepted; the jump then applies.
  - jumpAddr>=PROG_LEN: fault<=1, instrValid<=0, pc unchanged -> FAULT.
- FAULT: no fetches, instrValid=0, jumpEn ignored; exit only via nReset.
- run low in ISSUE/CAPTURE: the current fetch completes and is presented; the block stops in IDLE after its handshake.
- nReset low in any state takes effect at the next edge, overriding everything including a pending handshake.

Optional Feature:
- Macro: FETCH_BKPT_EN.
- Defined:
  - Adds ports bkptEn in 1, bkptAddr in ADDR_W, bkptHit out 1 (reset 0).
  - In ISSUE with bkptEn && pc==bkptAddr: no ROM issue; bkptHit pulses 1 cycle; -> IDLE.
  - The first ISSUE after leaving IDLE skips the compare, so resume does not re-hit immediately.
- Undefined: ports and logic absent; behaviour exactly as above.

Test Plan:
- Reset, run=1, instrReady=1, ROM holds mem[i]=i:
  - instrValid first high 2 cycles after run.
  - instr/instrPc sequence 0/0, 1/1 … 15/15, then wraps to 0/0.
  - One instruction every 3 cycles.
- Backpressure: instrReady=0 for 5 cycles at pc 3 -> instr=3 held stable, pc=4, no new romAddr change until accept.
- Jump to 12 while in CAPTURE for pc 5 -> instr 5 never valid; next delivered instr=12, instrPc=12, then 13.
- jumpAddr=20 with PROG_LEN=16 -> fault=1, instrValid=0, busy=0; further run/jumpEn ignored until nReset=0, after which pc=0, fault=0.
- run deasserted during ISSUE of pc 7 -> instr 7 delivered, then IDLE with pc=8; run reasserted -> next instr=8.
- FETCH_BKPT_EN with bkptAddr=4, bkptEn=1 -> instrs 0–3 delivered, bkptHit pulse, IDLE with pc=4; run again -> instr 4 delivered with no second hit.

Source files
------------

// File: rtl/tiny_fetch_sequencer.sv
// Instruction-fetch controller for the TinyMcu program ROM: owns the PC, handles the 1-cycle ROM latency.
// Optional ISSUE-stage breakpoint compare is compiled in when FETCH_BKPT_EN is defined.
module tiny_fetch_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int PROG_LEN = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              run,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [DATA_W-1:0] romData,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instrPc,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              jumpEn,
  input  logic [ADDR_W-1:0] jumpAddr,
  output logic              busy,
  output logic              fault
`ifdef FETCH_BKPT_EN
  ,
  input  logic              bkptEn,
  input  logic [ADDR_W-1:0] bkptAddr,
  output logic              bkptHit
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, FAULT} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W+1)'(PROG_LEN);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              handshake;
  logic              jump_ok;
`ifdef FETCH_BKPT_EN
  logic              bkpt_skip;
`endif

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PC) ? '0 : p + ADDR_W'(1);
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LEN_EXT;
  endfunction

  assign romAddr   = pc;
  assign handshake = instrValid && instrReady;
  assign jump_ok   = in_range(jumpAddr);
  assign busy      = (state != IDLE) && (state != FAULT);

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state      <= IDLE;
      pc         <= START_PC;
      instr      <= '0;
      instrPc    <= '0;
      instrValid <= 1'b0;
      fault      <= 1'b0;
`ifdef FETCH_BKPT_EN
      bkptHit    <= 1'b0;
      bkpt_skip  <= 1'b0;
`endif
    end else begin
`ifdef FETCH_BKPT_EN
      bkptHit <= 1'b0;
`endif
      // A redirect beats every other transition; a same-cycle handshake has already been observed.
      if (jumpEn && state != FAULT) begin
        instrValid <= 1'b0;
`ifdef FETCH_BKPT_EN
        bkpt_skip  <= 1'b0;
`endif
        if (jump_ok) begin
          pc <= jumpAddr;
          if (state != IDLE) state <= ISSUE;
        end else begin
          fault <= 1'b1;
          state <= FAULT;
        end
      end else begin
        case (state)
          IDLE: begin
            instrValid <= 1'b0;
            if (run) begin
              state <= ISSUE;
`ifdef FETCH_BKPT_EN
              bkpt_skip <= 1'b1;
`endif
            end
          end
          ISSUE: begin
`ifdef FETCH_BKPT_EN
            bkpt_skip <= 1'b0;
            if (bkptEn && pc == bkptAddr && !bkpt_skip) begin
              bkptHit <= 1'b1;
              state   <= IDLE;
            end else
`endif
            state <= CAPTURE;
          end
          // ROM has registered pc on the previous edge, so romData belongs to pc here.
          CAPTURE: begin
            instr      <= romData;
            instrPc    <= pc;
            instrValid <= 1'b1;
            pc         <= next_pc(pc);
            state      <= HOLD;
          end
          HOLD: begin
            if (handshake) begin
              instrValid <= 1'b0;
              state      <= run ? ISSUE : IDLE;
            end
          end
          FAULT: begin
            instrValid <= 1'b0;
          end
          default: begin
            instrValid <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tiny_fetch_sequencer.sv
// Directed bench for tiny_fetch_sequencer with a 1-cycle synchronous ROM model holding mem[i]=i.
module tb_tiny_fetch_sequencer;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clock;
  logic              nReset;
  logic              run;
  logic [ADDR_W-1:0] romAddr;
  logic [DATA_W-1:0] romData;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instrPc;
  logic              instrValid;
  logic              instrReady;
  logic              jumpEn;
  logic [ADDR_W-1:0] jumpAddr;
  logic              busy;
  logic              fault;
`ifdef FETCH_BKPT_EN
  logic              bkptEn;
  logic [ADDR_W-1:0] bkptAddr;
  logic              bkptHit;
`endif

  int checks = 0;
  int fails  = 0;

  logic [DATA_W-1:0] rom [32];

  tiny_fetch_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_LEN(16), .RESET_PC(0)
  ) dut (
    .clock(clock), .nReset(nReset), .run(run),
    .romAddr(romAddr), .romData(romData),
    .instr(instr), .instrPc(instrPc), .instrValid(instrValid), .instrReady(instrReady),
    .jumpEn(jumpEn), .jumpAddr(jumpAddr), .busy(busy), .fault(fault)
`ifdef FETCH_BKPT_EN
    , .bkptEn(bkptEn), .bkptAddr(bkptAddr), .bkptHit(bkptHit)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = (i < 16) ? DATA_W'(i) : DATA_W'(8'h80 + i);
  end

  always @(posedge clock) romData <= rom[romAddr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!instrValid && n < limit);
    check("valid_timeout", 32'(instrValid), 1);
  endtask

  initial begin
    int n;
    nReset = 0; run = 0; instrReady = 0; jumpEn = 0; jumpAddr = '0;
`ifdef FETCH_BKPT_EN
    bkptEn = 0; bkptAddr = '0;
`endif
    step(2);
    check("rst_valid", 32'(instrValid), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instrpc", 32'(instrPc), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_romaddr", 32'(romAddr), 0);

    // Free-running fetch: 0..15, wrap to 0, then 1..3; each one 3 cycles apart.
    nReset = 1; run = 1; instrReady = 1;
    for (int i = 0; i < 20; i++) begin
      wait_valid(10, n);
      check("seq_spacing", n, 3);
      check("seq_instr", 32'(instr), i % 16);
      check("seq_instrpc", 32'(instrPc), i % 16);
    end
    check("seq_pc_ahead", 32'(romAddr), 4);

    // Backpressure on instr 3.
    instrReady = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("bp_valid", 32'(instrValid), 1);
      check("bp_instr", 32'(instr), 3);
      check("bp_instrpc", 32'(instrPc), 3);
      check("bp_romaddr", 32'(romAddr), 4);
    end
    instrReady = 1;
    step(1);
    check("bp_release_valid", 32'(instrValid), 0);
    check("bp_release_romaddr", 32'(romAddr), 4);
    wait_valid(10, n);
    check("bp_next_lat", n, 2);
    check("bp_next_instr", 32'(instr), 4);

    // Jump to 12 while pc 5 is in CAPTURE.
    step(2);
    check("jmp_cap_romaddr", 32'(romAddr), 5);
    check("jmp_cap_valid", 32'(instrValid), 0);
    jumpEn = 1; jumpAddr = 5'd12;
    step(1);
    jumpEn = 0;
    check("jmp_valid", 32'(instrValid), 0);
    check("jmp_romaddr", 32'(romAddr), 12);
    wait_valid(10, n);
    check("jmp_lat", n, 2);
    check("jmp_instr", 32'(instr), 12);
    check("jmp_instrpc", 32'(instrPc), 12);
    wait_valid(10, n);
    check("jmp_next_instr", 32'(instr), 13);

    // Handshake plus jump to 7 in HOLD, then drop run while pc 7 is in ISSUE.
    jumpEn = 1; jumpAddr = 5'd7;
    step(1);
    jumpEn = 0; run = 0;
    check("stop_issue_romaddr", 32'(romAddr), 7);
    check("stop_issue_busy", 32'(busy), 1);
    wait_valid(10, n);
    check("stop_lat", n, 2);
    check("stop_instr", 32'(instr), 7);
    step(1);
    check("stop_idle_busy", 32'(busy), 0);
    check("stop_idle_valid", 32'(instrValid), 0);
    check("stop_idle_pc", 32'(romAddr), 8);
    step(2);
    check("stop_idle2_busy", 32'(busy), 0);
    check("stop_idle2_pc", 32'(romAddr), 8);
    run = 1;
    wait_valid(10, n);
    check("resume_lat", n, 3);
    check("resume_instr", 32'(instr), 8);

    // Out-of-range jump in HOLD -> sticky fault.
    jumpEn = 1; jumpAddr = 5'd20;
    step(1);
    check("flt_fault", 32'(fault), 1);
    check("flt_valid", 32'(instrValid), 0);
    check("flt_busy", 32'(busy), 0);
    check("flt_pc", 32'(romAddr), 9);
    jumpAddr = 5'd3; run = 1;
    step(4);
    check("flt_hold_fault", 32'(fault), 1);
    check("flt_hold_pc", 32'(romAddr), 9);
    check("flt_hold_valid", 32'(instrValid), 0);
    check("flt_hold_busy", 32'(busy), 0);
    nReset = 0;
    step(1);
    check("flt_rst_fault", 32'(fault), 0);
    check("flt_rst_pc", 32'(romAddr), 0);
    check("flt_rst_instr", 32'(instr), 0);
    check("flt_rst_instrpc", 32'(instrPc), 0);
    check("flt_rst_busy", 32'(busy), 0);

    // Valid jump while IDLE only moves the PC.
    nReset = 1; run = 0; jumpEn = 1; jumpAddr = 5'd10;
    step(1);
    check("idle_jmp_pc", 32'(romAddr), 10);
    check("idle_jmp_busy", 32'(busy), 0);
    jumpEn = 0; run = 1;
    wait_valid(10, n);
    check("idle_jmp_lat", n, 3);
    check("idle_jmp_instr", 32'(instr), 10);

    // jumpAddr == PROG_LEN is the first out-of-range target.
    jumpEn = 1; jumpAddr = 5'd16;
    step(1);
    jumpEn = 0;
    check("edge_flt_fault", 32'(fault), 1);
    check("edge_flt_pc", 32'(romAddr), 11);
    check("edge_flt_valid", 32'(instrValid), 0);

`ifdef FETCH_BKPT_EN
    nReset = 0; run = 0;
    step(1);
    check("bk_rst_hit", 32'(bkptHit), 0);
    bkptEn = 1; bkptAddr = 5'd4; nReset = 1; run = 1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(10, n);
      check("bk_seq_instr", 32'(instr), i);
    end
    step(1);
    check("bk_pre_hit", 32'(bkptHit), 0);
    step(1);
    check("bk_hit", 32'(bkptHit), 1);
    check("bk_hit_busy", 32'(busy), 0);
    check("bk_hit_pc", 32'(romAddr), 4);
    step(1);
    check("bk_hit_pulse", 32'(bkptHit), 0);
    check("bk_resume_busy", 32'(busy), 1);
    wait_valid(10, n);
    check("bk_resume_lat", n, 2);
    check("bk_resume_instr", 32'(instr), 4);
    check("bk_no_rehit", 32'(bkptHit), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
